// File: rtl/rv32i_types.sv
// Shared RV32 types: register width and the M-extension funct3 encodings.
package rv32i_types;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } muldiv_funct3_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if the divisor fits.
module div_step
  import rv32i_types::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividend_bit,
  output logic [XLEN-1:0] rem_next,
  output logic            quo_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  assign shifted  = {rem, dividend_bit};
  // rem < divisor on entry, so a successful subtraction always fits in XLEN bits
  assign diff     = shifted[XLEN-1:0] - divisor;
  assign quo_bit  = (shifted >= {1'b0, divisor});
  assign rem_next = quo_bit ? diff : shifted[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply, restoring divide.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result
);

  import rv32i_types::*;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int unsigned CntW = $clog2(XLEN);

  logic [1:0]        state_q;
  logic [CntW-1:0]   cnt_q;
  muldiv_funct3_t    op_q;
  logic [2*XLEN-1:0] acc_q, mcand_q;
  logic [XLEN-1:0]   mplier_q, rem_q, dvsr_q, quo_q, result_q;
  logic              neg_q_q, neg_r_q;

  muldiv_funct3_t    op_in;
  logic              a_signed, b_signed, is_div, sdiv, a_neg, b_neg, div0, ovf;
  logic [2*XLEN-1:0] mcand_init, acc_init, acc_nx;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, rem_nx, quo_nx, final_res;
  logic              qbit;

  assign op_in    = muldiv_funct3_t'(op);
  assign a_signed = op_in inside {OpMul, OpMulh, OpMulhsu};
  assign b_signed = op_in inside {OpMul, OpMulh};
  assign is_div   = op[2];
  assign sdiv     = is_div & ~op[0];
  assign a_neg    = sdiv & a[XLEN-1];
  assign b_neg    = sdiv & b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div0     = is_div && (b == '0);
  assign ovf      = sdiv && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

  // A negative 33-bit multiplier's top bit weighs -2^XLEN; pre-load that term so the
  // XLEN shift-add iterations only cover the low bits.
  assign mcand_init = {{XLEN{a_signed & a[XLEN-1]}}, a};
  assign acc_init   = (b_signed & b[XLEN-1]) ? -{mcand_init[XLEN-1:0], {XLEN{1'b0}}} : '0;

  always_comb begin
    special_res = '0;
    if (div0)     special_res = op[1] ? a : '1;
    else if (ovf) special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

  div_step u_div_step (
    .rem          (rem_q),
    .divisor      (dvsr_q),
    .dividend_bit (quo_q[XLEN-1]),
    .rem_next     (rem_nx),
    .quo_bit      (qbit)
  );

  assign quo_nx = {quo_q[XLEN-2:0], qbit};

  always_comb begin
    final_res = '0;
    case (op_q)
      OpMul:                     final_res = acc_nx[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: final_res = acc_nx[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             final_res = neg_q_q ? -quo_nx : quo_nx;
      default:                   final_res = neg_r_q ? -rem_nx : rem_nx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OpMul;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      quo_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q     <= op_in;
            cnt_q    <= '0;
            acc_q    <= acc_init;
            mcand_q  <= mcand_init;
            mplier_q <= b;
            rem_q    <= '0;
            dvsr_q   <= b_mag;
            quo_q    <= a_mag;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            if (div0 || ovf) begin
              state_q  <= DONE;
              result_q <= special_res;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_q    <= acc_nx;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          rem_q    <= rem_nx;
          quo_q    <= quo_nx;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) begin
            state_q  <= DONE;
            result_q <= final_res;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state_q  <= IDLE;
            result_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign result     = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latencies, backpressure, flush and reset.
module tb_muldiv_unit;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, resp_ready;
  logic        req_ready, resp_valid;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive a request at a negedge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_issue", {31'b0, req_ready}, 32'd1);
    op = o; a = x; b = y; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Cycles after the accept cycle until resp_valid is seen (100 = timed out).
  task automatic wait_resp(output int lat);
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(o, x, y);
    wait_resp(lat);
    check(tag, result, exp);
    if (exp_lat != 0) check({tag, "_lat"}, lat, exp_lat);
    take_resp();
  endtask

  task automatic expect_silent(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_result", result, 32'd0);

    run("mul_7_m3",       OpMul,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run("mulh_min_min",   OpMulh,   32'h80000000, 32'h80000000, 32'h40000000, 0);
    run("mulhu_max_max",  OpMulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    run("mulhsu_m1_2",    OpMulhsu, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0);
    run("mulhsu_2_big",   OpMulhsu, 32'd2,        32'h80000000, 32'h00000001, 0);
    run("mulh_m1_m1",     OpMulh,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0);
    run("div_m7_2",       OpDiv,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run("rem_m7_2",       OpRem,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
    run("divu_100_7",     OpDivu,   32'd100,      32'd7,        32'd14,       0);
    run("remu_100_7",     OpRemu,   32'd100,      32'd7,        32'd2,        0);
    run("div_100_m7",     OpDiv,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 0);
    run("rem_100_m7",     OpRem,    32'd100,      32'hFFFFFFF9, 32'd2,        0);
    run("divu_max_1",     OpDivu,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 0);
    run("divu_by0",       OpDivu,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run("rem_by0",        OpRem,    32'd5,        32'd0,        32'd5,        1);
    run("div_ovf",        OpDiv,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem_ovf",        OpRem,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Backpressure in DONE, then no same-cycle re-accept.
    issue(OpMul, 32'h12345, 32'h10);
    @(negedge clk);
    check("busy_result_zero", result, 32'd0);
    wait_resp(lat);
    check("hold_first", result, 32'h00123450);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_result", result, 32'h00123450);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      check("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
    end
    op = OpMul; a = 32'd1; b = 32'd1; req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("leave_req_ready", {31'b0, req_ready}, 32'd1);
    check("leave_result", result, 32'd0);
    req_valid = 1'b0;

    // Flush at iteration 10 of BUSY.
    issue(OpMul, 32'd5, 32'd6);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_req_ready", {31'b0, req_ready}, 32'd1);
    expect_silent("flush_no_resp", 40);
    run("mul_3_4", OpMul, 32'd3, 32'd4, 32'd12, 33);

    // Flush beats acceptance.
    @(negedge clk);
    op = OpMul; a = 32'd2; b = 32'd2; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin req_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("flush_vs_accept", {31'b0, req_ready}, 32'd1);

    // Flush beats the response handshake and discards the result.
    issue(OpDivu, 32'd5, 32'd0);
    wait_resp(lat);
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    #1 begin flush = 1'b0; resp_ready = 1'b0; end
    @(negedge clk);
    check("flush_done_result", result, 32'd0);
    check("flush_done_valid", {31'b0, resp_valid}, 32'd0);

    // Reset mid-BUSY, held together with flush.
    issue(OpDiv, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin rst = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    expect_silent("midrst_no_resp", 40);
    run("remu_after_rst", OpRemu, 32'd100, 32'd7, 32'd2, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 flush  input  1  aborts any in-flight operation.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 op  input  3  M-extension funct3: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
REQ-008 a, b  input  32 each  rs1 / rs2 operands.
REQ-009 resp_valid  output  1  result valid.
REQ-010 resp_ready  input  1  consumer accepts the result.
REQ-011 result  output  32  operation result.

Function
REQ-012 The FSM SHALL have the states IDLE, BUSY, DONE.
REQ-013 req_ready SHALL equal (state==IDLE).
REQ-014 In IDLE, req_valid=1 SHALL latch op, a and b, and enter BUSY with the iteration counter set to 0, or enter DONE directly for a special case.
REQ-015 Multiply SHALL be shift-add over 32 iterations on operands sign- or zero-extended to 33 bits per op, producing a 64-bit product.
REQ-016 mul SHALL return product[31:0]; mulh, mulhsu and mulhu SHALL return product[63:32].
REQ-017 Divide SHALL be restoring, 1 quotient bit per cycle over 32 iterations, on magnitudes.
REQ-018 Divide sign fix-up: quotient is negated if the operand signs differ; remainder takes the sign of a (signed ops only).
REQ-019 BUSY SHALL last exactly 32 cycles, then go to DONE; resp_valid is first high in the 33rd cycle after the accept cycle.
REQ-020 Special case, divide by zero (b==0): quotient = 0xFFFFFFFF and remainder = a, reaching DONE in the cycle after accept.
REQ-021 Special case, signed overflow (div/rem with a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000 and remainder = 0, reaching DONE in the cycle after accept.
REQ-022 In DONE, resp_valid=1 and result SHALL hold stable until resp_ready=1; that cycle returns to IDLE.
REQ-023 No new request SHALL be accepted in the cycle DONE is left (no bypass).
REQ-024 flush=1 SHALL force IDLE on the next edge from any state and discard the result; flush has priority over acceptance and over the resp handshake.
REQ-025 result SHALL be 0 whenever resp_valid=0.

Reset
REQ-026 rst=1 SHALL set state=IDLE, counter=0, all operand/accumulator registers=0, resp_valid=0, result=0 and req_ready=1 on the next edge.
REQ-027 rst mid-operation SHALL discard the operation with no response; rst SHALL override flush and all handshakes.

Structure
REQ-028 The muldiv_funct3_t enum and the constant XLEN SHALL live in the shared rv32i_types package.
REQ-029 The FSM, counter and datapath SHALL live in muldiv_unit.
REQ-030 The single iteration step of divide SHALL be the combinational sub-module div_step, which takes (rem, divisor, dividend bit) and returns (next rem, quotient bit).

Verification
REQ-031 mul a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; resp_valid first high in the 33rd cycle after accept.
REQ-032 mulh a=b=0x80000000 -> 0x40000000; mulhu a=b=0xFFFFFFFF -> 0xFFFFFFFE; mulhsu a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-033 div a=0xFFFFFFF9, b=2 -> 0xFFFFFFFD; rem with the same operands -> 0xFFFFFFFF; divu a=100, b=7 -> 14; remu a=100, b=7 -> 2.
REQ-034 divu a=5, b=0 -> 0xFFFFFFFF and rem a=5, b=0 -> 5, each with resp_valid in the cycle after accept; div a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
REQ-035 Hold resp_ready=0 for 5 cycles in DONE -> result stable and req_ready=0 throughout; one cycle after resp_ready=1 -> req_ready=1.
REQ-036 flush at BUSY iteration 10 -> IDLE next cycle with no resp_valid; a new mul 3*4 then returns 12. rst mid-BUSY -> all outputs at reset values.
